// File: rtl/adjust_button_decoder.sv
// rtl/adjust_button_decoder.sv - sync, debounce, hold-to-repeat and two-button clear for adjust buttons
module adjust_button_decoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 4
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    input  logic       i_enable,
    output logic       o_up,
    output logic       o_down,
    output logic [1:0] o_pressed
);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic [2:0] {IDLE, UP_DELAY, UP_REPEAT, DN_DELAY, DN_REPEAT, LOCK} state_t;

    // Bit 1 is the up button, bit 0 the down button throughout.
    logic [1:0]    sync1, sync2, level;
    logic [DW-1:0] dcnt [2];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {i_btn_up, i_btn_down};
            sync2 <= sync1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            level   <= '0;
            dcnt[0] <= '0;
            dcnt[1] <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (sync2[b] == level[b]) begin
                    dcnt[b] <= '0;
                end else if (dcnt[b] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    level[b] <= sync2[b];
                    dcnt[b]  <= '0;
                end else begin
                    dcnt[b] <= dcnt[b] + 1'b1;
                end
            end
        end
    end

    assign o_pressed = level;

    state_t        state, state_nx;
    logic [RW-1:0] rcnt, rcnt_nx, rpt_limit;
    logic          up_nx, dn_nx, going_up, held, other;

    assign going_up  = (state == UP_DELAY) || (state == UP_REPEAT);
    assign held      = going_up ? level[1] : level[0];
    assign other     = going_up ? level[0] : level[1];
    assign rpt_limit = ((state == UP_DELAY) || (state == DN_DELAY)) ?
                       RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state  <= IDLE;
            rcnt   <= '0;
            o_up   <= 1'b0;
            o_down <= 1'b0;
        end else begin
            state  <= state_nx;
            rcnt   <= rcnt_nx;
            o_up   <= up_nx;
            o_down <= dn_nx;
        end
    end

    always_comb begin
        state_nx = state;
        rcnt_nx  = rcnt;
        up_nx    = 1'b0;
        dn_nx    = 1'b0;
        if (!i_enable) begin
            state_nx = IDLE;
            rcnt_nx  = '0;
        end else begin
            case (state)
                IDLE: begin
                    rcnt_nx = '0;
                    if (level[1] && level[0]) begin
                        up_nx    = 1'b1;
                        dn_nx    = 1'b1;
                        state_nx = LOCK;
                    end else if (level[1]) begin
                        up_nx    = 1'b1;
                        state_nx = UP_DELAY;
                    end else if (level[0]) begin
                        dn_nx    = 1'b1;
                        state_nx = DN_DELAY;
                    end
                end
                UP_DELAY, UP_REPEAT, DN_DELAY, DN_REPEAT: begin
                    // Release and clear are checked before the repeat strobe so they win in the same cycle.
                    if (!held) begin
                        state_nx = IDLE;
                        rcnt_nx  = '0;
                    end else if (other) begin
                        up_nx    = 1'b1;
                        dn_nx    = 1'b1;
                        state_nx = LOCK;
                        rcnt_nx  = '0;
                    end else if (rcnt == rpt_limit) begin
                        rcnt_nx = '0;
                        if (going_up) begin
                            up_nx    = 1'b1;
                            state_nx = UP_REPEAT;
                        end else begin
                            dn_nx    = 1'b1;
                            state_nx = DN_REPEAT;
                        end
                    end else begin
                        rcnt_nx = rcnt + 1'b1;
                    end
                end
                LOCK: begin
                    rcnt_nx = '0;
                    if (!level[1] && !level[0]) state_nx = IDLE;
                end
                default: begin
                    state_nx = IDLE;
                    rcnt_nx  = '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adjust_button_decoder.sv
// tb/tb_adjust_button_decoder.sv - directed-vector bench for adjust_button_decoder
module tb_adjust_button_decoder;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       enable = 1'b0;
    logic       up, down;
    logic [1:0] pressed;

    adjust_button_decoder dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_btn_up   (btn_up),
        .i_btn_down (btn_down),
        .i_enable   (enable),
        .o_up       (up),
        .o_down     (down),
        .o_pressed  (pressed)
    );

    always #5 clk = ~clk;

    // cyc is the number of rising edges so far; a strobe registered at edge n is logged as n.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int up_q[$];
    int dn_q[$];
    always @(negedge clk) begin
        if (up)   up_q.push_back(cyc);
        if (down) dn_q.push_back(cyc);
    end

    int total = 0;
    int passed = 0;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int q_at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic clear_q();
        up_q.delete();
        dn_q.delete();
    endtask

    int k, t, mask;

    initial begin
        tick(3);
        check("reset_up", up, 0);
        check("reset_down", down, 0);
        check("reset_pressed", pressed, 0);
        rstn = 1'b1;
        enable = 1'b1;
        tick(5);

        // single press
        clear_q();
        k = cyc;
        btn_up = 1'b1;
        tick(8);
        check("single_pressed_hold", pressed, 2);
        tick(2);
        btn_up = 1'b0;
        tick(20);
        check("single_up_count", up_q.size(), 1);
        check("single_up_time", q_at(up_q, 0), k + 7);
        check("single_down_count", dn_q.size(), 0);
        check("single_pressed_released", pressed, 0);

        // bounce: toggle every 2 cycles, then stable high
        clear_q();
        k = cyc;
        mask = 0;
        for (int i = 0; i < 20; i++) begin
            btn_up = ((i / 2) % 2) == 0;
            tick(1);
            mask |= pressed;
        end
        check("bounce_pressed", mask, 0);
        check("bounce_no_strobe", up_q.size(), 0);
        btn_up = 1'b1;
        tick(10);
        btn_up = 1'b0;
        tick(20);
        check("bounce_up_count", up_q.size(), 1);
        check("bounce_up_time", q_at(up_q, 0), k + 27);

        // auto-repeat on down
        clear_q();
        k = cyc;
        t = k + 7;
        btn_down = 1'b1;
        tick(60);
        btn_down = 1'b0;
        tick(30);
        check("repeat_count", dn_q.size(), 12);
        check("repeat_first", q_at(dn_q, 0), t);
        for (int j = 1; j < 12; j++)
            check($sformatf("repeat_%0d", j), q_at(dn_q, j), t + 12 + 4 * j);
        check("repeat_no_up", up_q.size(), 0);

        // clear gesture
        clear_q();
        k = cyc;
        btn_up = 1'b1;
        tick(12);
        btn_down = 1'b1;
        tick(10);
        check("clear_pressed_both", pressed, 3);
        tick(8);
        btn_up = 1'b0;
        btn_down = 1'b0;
        tick(20);
        check("clear_up_count", up_q.size(), 2);
        check("clear_up_first", q_at(up_q, 0), k + 7);
        check("clear_up_clear", q_at(up_q, 1), k + 19);
        check("clear_down_count", dn_q.size(), 1);
        check("clear_down_clear", q_at(dn_q, 0), k + 19);
        clear_q();
        k = cyc;
        btn_up = 1'b1;
        tick(10);
        btn_up = 1'b0;
        tick(20);
        check("clear_fresh_count", up_q.size(), 1);
        check("clear_fresh_time", q_at(up_q, 0), k + 7);

        // enable gating
        clear_q();
        k = cyc;
        enable = 1'b0;
        btn_up = 1'b1;
        tick(40);
        check("disabled_no_strobe", up_q.size(), 0);
        check("disabled_pressed", pressed, 2);
        enable = 1'b1;
        tick(18);
        btn_up = 1'b0;
        tick(30);
        check("enable_count", up_q.size(), 3);
        check("enable_first", q_at(up_q, 0), k + 41);
        check("enable_repeat1", q_at(up_q, 1), k + 57);
        check("enable_repeat2", q_at(up_q, 2), k + 61);
        check("enable_no_down", dn_q.size(), 0);

        // reset mid-repeat
        clear_q();
        k = cyc;
        btn_up = 1'b1;
        tick(25);
        check("prereset_strobes", up_q.size(), 2);
        check("prereset_pressed", pressed, 2);
        rstn = 1'b0;
        #1;
        check("midreset_up", up, 0);
        check("midreset_down", down, 0);
        check("midreset_pressed", pressed, 0);
        clear_q();
        tick(3);
        k = cyc;
        rstn = 1'b1;
        tick(12);
        btn_up = 1'b0;
        tick(20);
        check("postreset_count", up_q.size(), 1);
        check("postreset_time", q_at(up_q, 0), k + 7);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
